// File: rtl/cpm_pkg.sv
// Shared defaults and the read-tag record for the CPM response path.
package cpm_pkg;

    localparam int CPM_REQ_DW   = 4;
    localparam int CPM_IDX_AW   = 2;
    localparam int CPM_ADR_AW   = 8;
    localparam int CPM_DAT_DW   = 16;
    localparam int CPM_RD_LAT   = 2;
    localparam int CPM_FIFO_DEP = 4;
    localparam int CPM_PID_W    = $clog2(CPM_REQ_DW);

    // Travels beside each bank read so returning data finds its requester.
    typedef struct packed {
        logic                 vld;
        logic [CPM_PID_W-1:0] port;
    } tag_t;

endpackage

// File: rtl/cpm_rsp_mo_if.sv
// Requester/bank/response bundle of the CPM response mux; slave is the mux side.
interface cpm_rsp_mo_if #(
    parameter int REQ_DW = cpm_pkg::CPM_REQ_DW,
    parameter int IDX_AW = cpm_pkg::CPM_IDX_AW,
    parameter int ADR_AW = cpm_pkg::CPM_ADR_AW,
    parameter int DAT_DW = cpm_pkg::CPM_DAT_DW
);
    logic [REQ_DW-1:0]        GNT_ARB;
    logic [REQ_DW*IDX_AW-1:0] REQ_IDX;
    logic [REQ_DW*ADR_AW-1:0] REQ_ADR;
    logic [REQ_DW-1:0]        BNK_CE;
    logic [REQ_DW*ADR_AW-1:0] BNK_ADR;
    logic [REQ_DW*DAT_DW-1:0] BNK_DAT;
    logic [REQ_DW-1:0]        RSP_VLD;
    logic [REQ_DW*DAT_DW-1:0] RSP_DAT;
    logic [REQ_DW-1:0]        RSP_RDY;
    logic [REQ_DW-1:0]        PORT_STALL;
    logic [1:0]               ERR;

    modport slave (
        input  GNT_ARB, REQ_IDX, REQ_ADR, BNK_DAT, RSP_RDY,
        output BNK_CE, BNK_ADR, RSP_VLD, RSP_DAT, PORT_STALL, ERR
    );

    modport master (
        output GNT_ARB, REQ_IDX, REQ_ADR, BNK_DAT, RSP_RDY,
        input  BNK_CE, BNK_ADR, RSP_VLD, RSP_DAT, PORT_STALL, ERR
    );

endinterface

// File: rtl/cpm_rsp_fifo.sv
// Show-ahead response FIFO (power-of-two depth); write-to-head latency 1 cycle.
// Backpressure via rd_rdy; a push is dropped only if full with no pop (upstream credits prevent it).
module cpm_rsp_fifo #(
    parameter int DW  = 16,
    parameter int DEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    output logic [DW-1:0] rd_dat,
    input  logic          rd_rdy
);
    localparam int AW = $clog2(DEP);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEP);

    logic [DW-1:0] mem [DEP];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign rd_vld  = (cnt != '0);
    assign rd_dat  = mem[rd_ptr];
    assign do_pop  = rd_vld & rd_rdy;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = wr_vld & ((cnt != CNT_FULL) | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cpm_rsp_mo.sv
// Banked read crossbar with per-port in-order response FIFOs; grant-to-RSP_VLD RD_LAT+1 cycles.
// Credits bound outstanding reads to FIFO_DEP per port; PORT_STALL asks upstream to mask a full port.
module cpm_rsp_mo
    import cpm_pkg::*;
#(
    parameter int REQ_DW   = CPM_REQ_DW,
    parameter int IDX_AW   = CPM_IDX_AW,
    parameter int ADR_AW   = CPM_ADR_AW,
    parameter int DAT_DW   = CPM_DAT_DW,
    parameter int RD_LAT   = CPM_RD_LAT,
    parameter int FIFO_DEP = CPM_FIFO_DEP
) (
    input logic         clk,
    input logic         rst_n,
    cpm_rsp_mo_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEP) + 1;
    localparam logic [CW-1:0] CRD_MAX = CW'(FIFO_DEP);

    logic [CW-1:0]        credit   [REQ_DW];
    logic [ADR_AW-1:0]    bnk_adr  [REQ_DW];
    logic [CPM_PID_W-1:0] win      [REQ_DW];
    logic [DAT_DW-1:0]    push_dat [REQ_DW];
    logic [DAT_DW-1:0]    rsp_dat  [REQ_DW];
    tag_t                 tag_sr   [REQ_DW][RD_LAT];

    logic [REQ_DW-1:0] stall, elig, served, pop, push, rsp_vld, bnk_ce;
    logic              collide, overflow;
    logic [1:0]        err;

    always_comb begin
        stall = '0;
        for (int p = 0; p < REQ_DW; p++) begin
            stall[p] = (credit[p] == CRD_MAX);
        end
    end

    assign elig     = bus.GNT_ARB & ~stall;
    assign overflow = |(bus.GNT_ARB & stall);
    assign pop      = rsp_vld & bus.RSP_RDY;

    // Bank decode: scanning ports upward, the first hit on a bank wins.
    always_comb begin
        bnk_ce  = '0;
        served  = '0;
        collide = 1'b0;
        for (int b = 0; b < REQ_DW; b++) begin
            bnk_adr[b] = '0;
            win[b]     = '0;
        end
        for (int b = 0; b < REQ_DW; b++) begin
            for (int p = 0; p < REQ_DW; p++) begin
                if (elig[p] && (bus.REQ_IDX[p*IDX_AW +: IDX_AW] == IDX_AW'(b))) begin
                    if (bnk_ce[b]) begin
                        collide = 1'b1;
                    end else begin
                        bnk_ce[b]  = 1'b1;
                        bnk_adr[b] = bus.REQ_ADR[p*ADR_AW +: ADR_AW];
                        win[b]     = CPM_PID_W'(p);
                        served[p]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < REQ_DW; b++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    tag_sr[b][s] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < REQ_DW; b++) begin
                tag_sr[b][0] <= '{vld: bnk_ce[b], port: win[b]};
                for (int s = 1; s < RD_LAT; s++) begin
                    tag_sr[b][s] <= tag_sr[b][s-1];
                end
            end
        end
    end

    // A port is granted at most one bank per cycle, so exits never double up on a port.
    always_comb begin
        push = '0;
        for (int p = 0; p < REQ_DW; p++) begin
            push_dat[p] = '0;
        end
        for (int b = 0; b < REQ_DW; b++) begin
            if (tag_sr[b][RD_LAT-1].vld) begin
                for (int p = 0; p < REQ_DW; p++) begin
                    if (tag_sr[b][RD_LAT-1].port == CPM_PID_W'(p)) begin
                        push[p]     = 1'b1;
                        push_dat[p] = bus.BNK_DAT[b*DAT_DW +: DAT_DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < REQ_DW; p++) begin
                credit[p] <= '0;
            end
            err <= '0;
        end else begin
            for (int p = 0; p < REQ_DW; p++) begin
                case ({served[p], pop[p]})
                    2'b10:   credit[p] <= credit[p] + CW'(1);
                    2'b01:   credit[p] <= credit[p] - CW'(1);
                    default: credit[p] <= credit[p];
                endcase
            end
            err <= err | {collide, overflow};
        end
    end

    for (genvar p = 0; p < REQ_DW; p++) begin : g_fifo
        cpm_rsp_fifo #(
            .DW  (DAT_DW),
            .DEP (FIFO_DEP)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_vld (push[p]),
            .wr_dat (push_dat[p]),
            .rd_vld (rsp_vld[p]),
            .rd_dat (rsp_dat[p]),
            .rd_rdy (bus.RSP_RDY[p])
        );
    end

    always_comb begin
        bus.BNK_ADR = '0;
        bus.RSP_DAT = '0;
        for (int b = 0; b < REQ_DW; b++) begin
            bus.BNK_ADR[b*ADR_AW +: ADR_AW] = bnk_adr[b];
            bus.RSP_DAT[b*DAT_DW +: DAT_DW] = rsp_dat[b];
        end
        bus.BNK_CE     = bnk_ce;
        bus.RSP_VLD    = rsp_vld;
        bus.PORT_STALL = stall;
        bus.ERR        = err;
    end

endmodule

// File: tb/tb_cpm_rsp_mo.sv
// Directed bench for cpm_rsp_mo with a 2-cycle bank memory model.
module tb_cpm_rsp_mo;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpm_rsp_mo_if bus ();

    cpm_rsp_mo u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] bd0 [4];
    logic [15:0] bd1 [4];
    logic [15:0] t5_exp [7] = '{16'h1DB1, 16'h1DB2, 16'h1DB3, 16'h1DC0,
                                16'h1DC1, 16'h1DC2, 16'h1DC3};

    function automatic logic [15:0] bank_word(input int b, input logic [7:0] a);
        if (b == 1 && a == 8'h15) return 16'hBEEF;
        return {4'(b), 4'hD, a};
    endfunction

    // Bank memory: data appears two cycles after the address.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            bd0[b] <= bank_word(b, bus.BNK_ADR[b*8 +: 8]);
            bd1[b] <= bd0[b];
        end
    end

    always_comb begin
        bus.BNK_DAT = '0;
        for (int b = 0; b < 4; b++) begin
            bus.BNK_DAT[b*16 +: 16] = bd1[b];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] g, input logic [7:0] idx, input logic [31:0] adr);
        bus.GNT_ARB = g;
        bus.REQ_IDX = idx;
        bus.REQ_ADR = adr;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.RSP_RDY = 4'hF;
        drive(4'h0, 8'h00, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_vld",   bus.RSP_VLD, 4'h0);
        chk("rst_stall", bus.PORT_STALL, 4'h0);
        chk("rst_err",   bus.ERR, 2'b00);
        chk("rst_ce",    bus.BNK_CE, 4'h0);

        // single grant: port2 -> bank1 @0x15
        tick(); drive(4'b0100, 8'h10, 32'h0015_0000);
        chk("t1_ce",  bus.BNK_CE, 4'b0010);
        chk("t1_adr", bus.BNK_ADR, 32'h0000_1500);
        chk("t1_vld_c0", bus.RSP_VLD, 4'h0);
        tick(); drive(4'h0, 8'h00, 32'h0);
        chk("t1_vld_c1", bus.RSP_VLD, 4'h0);
        tick();
        chk("t1_vld_c2", bus.RSP_VLD, 4'h0);
        tick();
        chk("t1_vld_c3", bus.RSP_VLD, 4'b0100);
        chk("t1_dat",    bus.RSP_DAT[47:32], 16'hBEEF);
        tick();
        chk("t1_vld_c4", bus.RSP_VLD, 4'h0);

        // all four ports to banks 3,2,1,0
        tick(); drive(4'hF, 8'h1B, 32'h4332_2110);
        chk("t2_ce",  bus.BNK_CE, 4'hF);
        chk("t2_adr", bus.BNK_ADR, 32'h1021_3243);
        tick(); drive(4'h0, 8'h00, 32'h0);
        tick();
        chk("t2_vld_c2", bus.RSP_VLD, 4'h0);
        tick();
        chk("t2_vld_c3", bus.RSP_VLD, 4'hF);
        chk("t2_dat",    bus.RSP_DAT, 64'h0D43_1D32_2D21_3D10);
        chk("t2_err",    bus.ERR, 2'b00);
        tick();
        chk("t2_vld_c4", bus.RSP_VLD, 4'h0);

        // collision: ports 1 and 3 on bank 0
        tick(); drive(4'b1010, 8'h00, 32'h6600_5500);
        chk("t3_ce",  bus.BNK_CE, 4'b0001);
        chk("t3_adr", bus.BNK_ADR, 32'h0000_0055);
        tick(); drive(4'h0, 8'h00, 32'h0);
        chk("t3_err", bus.ERR, 2'b10);
        tick();
        tick();
        chk("t3_vld", bus.RSP_VLD, 4'b0010);
        chk("t3_dat", bus.RSP_DAT[31:16], 16'h0D55);
        tick();
        chk("t3_vld_after", bus.RSP_VLD, 4'h0);

        // backpressure on port0: fill, overflow, drain
        bus.RSP_RDY = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick(); drive(4'b0001, 8'h02, 32'h0000_00A0 + i);
            chk("t4_stall_pre", bus.PORT_STALL, 4'h0);
            chk("t4_ce",        bus.BNK_CE, 4'b0100);
        end
        tick(); drive(4'b0001, 8'h02, 32'h0000_00A4);
        chk("t4_stall",  bus.PORT_STALL, 4'b0001);
        chk("t4_ce_sup", bus.BNK_CE, 4'h0);
        tick(); drive(4'h0, 8'h00, 32'h0);
        chk("t4_err", bus.ERR, 2'b11);
        tick();
        chk("t4_full_vld", bus.RSP_VLD, 4'b0001);
        chk("t4_full_dat", bus.RSP_DAT[15:0], 16'h2DA0);
        tick();
        bus.RSP_RDY = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_drain_vld", bus.RSP_VLD, 4'b0001);
            chk("t4_drain_dat", bus.RSP_DAT[15:0], 64'(16'h2DA0 + i));
            tick();
        end
        chk("t4_empty", bus.RSP_VLD, 4'h0);
        chk("t4_unstall", bus.PORT_STALL, 4'h0);

        // full FIFO, then pop concurrent with grants and tag-exit pushes
        bus.RSP_RDY = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick(); drive(4'b0001, 8'h01, 32'h0000_00B0 + i);
        end
        tick(); drive(4'h0, 8'h00, 32'h0);
        tick();
        tick();
        chk("t5_full_stall", bus.PORT_STALL, 4'b0001);
        chk("t5_full_dat",   bus.RSP_DAT[15:0], 16'h1DB0);
        bus.RSP_RDY = 4'hF;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 4) begin
                drive(4'b0001, 8'h01, 32'h0000_00C0 + i);
                chk("t5_ce", bus.BNK_CE, 4'b0010);
            end else begin
                drive(4'h0, 8'h00, 32'h0);
            end
            chk("t5_stall", bus.PORT_STALL, 4'h0);
            chk("t5_vld",   bus.RSP_VLD, 4'b0001);
            chk("t5_dat",   bus.RSP_DAT[15:0], t5_exp[i]);
        end
        tick();
        chk("t5_empty", bus.RSP_VLD, 4'h0);

        // reset one cycle after a grant discards the read
        tick(); drive(4'b0001, 8'h00, 32'h0000_0077);
        tick(); drive(4'h0, 8'h00, 32'h0);
        rst_n = 1'b0;
        chk("t6_err_pre", bus.ERR, 2'b11);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_err_clr", bus.ERR, 2'b00);
        chk("t6_stall",   bus.PORT_STALL, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_novld", bus.RSP_VLD, 4'h0);
        end
        bus.RSP_RDY = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick(); drive(4'b0001, 8'h02, 32'h0000_0010 + i);
            chk("t6_crd_pre", bus.PORT_STALL, 4'h0);
        end
        tick(); drive(4'h0, 8'h00, 32'h0);
        chk("t6_crd_full", bus.PORT_STALL, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
